sine_phase_fold: RTL and testbench
==================================

Name: sine_phase_fold

Overview:
- Numerically controlled phase generator and quadrant folder; the stage directly upstream of sine_taylor.
- Accumulates a phase word every sample and folds the phase into a signed triangle argument x in [-1,1), Q1.(G_DWIDTH-1).
- The downstream evaluator, sin(pi/2*x), then yields sin(2*pi*phase). Output is a valid/ready stream sized to feed sine_taylor.din directly.

Parameters:
- G_PWIDTH, 32, phase accumulator width (unsigned turns, full scale = 1 turn); must be >= G_DWIDTH+1.
- G_DWIDTH, 16, output sample width (signed Q1.(G_DWIDTH-1)).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  0 = synchronous flush of valids; phase held.
- bypass  in  1  1 = output raw phase MSBs (sawtooth) instead of fold.
- phase_inc  in  G_PWIDTH  frequency word, sampled on every pipeline advance.
- phase_load  in  1  one-cycle pulse: load accumulator.
- phase_load_val  in  G_PWIDTH  value loaded on phase_load.
- dout  out  G_DWIDTH  folded argument.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.

Behaviour:
- Reset (reset_n=0, async): acc=0, s1_phase=0, s1_valid=0, dout=0, dout_valid=0, LFSR=0xACE1.
- advance = enable & (!dout_valid | dout_ready). Without advance, all registers hold and dout stays stable while dout_valid=1.
- On advance:
  - s1_phase <= acc (+ dither, see option); s1_valid <= 1.
  - acc <= acc + phase_inc (mod 2^G_PWIDTH, wraps silently).
  - dout <= fold(s1_phase); dout_valid <= s1_valid.
- Latency: 2 advances from the acc value to dout. First valid output after reset release with enable=1 and dout_ready=1 appears on the 2nd rising edge and carries phase 0.
- Throughput: 1 sample/cycle with dout_ready held high.
- phase_load has priority over advance, regardless of enable:
  - acc <= phase_load_val; s1_valid <= 0; dout_valid <= 0. Stale samples are discarded, never emitted.
  - Next output carries phase_load_val exactly, 2 cycles later.
- enable=0: s1_valid <= 0, dout_valid <= 0; acc, LFSR and data registers hold. Re-enable resumes from the held acc.
- Fold, with p = G_PWIDTH, d = G_DWIDTH, quad = s1_phase[p-1:p-2], f = s1_phase[p-3:p-d-1] (unsigned, d-1 bits), H = 2^(d-1):
  - quad 0: x = f.
  - quad 1: x = H - f; f=0 saturates to H-1 (0x7FFF).
  - quad 2: x = -f.
  - quad 3: x = f - H (f=0 gives -H = 0x8000, exact).
  - Remaining LSBs are truncated, not rounded.
- bypass=1: dout <= s1_phase[p-1:p-d] (sawtooth). Pipeline timing is unchanged. bypass is sampled per advance, so a mid-stream toggle affects only later samples.
- Reset asserted mid-stream: immediate async clear; no partial handshake survives.

Optional Feature:
- SINE_PHASE_DITHER_EN defined:
  - 16-bit Galois LFSR, mask 0xB400, seed 0xACE1, steps once per advance.
  - Its low min(16, G_PWIDTH-G_DWIDTH-1) bits are added to acc (mod 2^p) when forming s1_phase. acc itself is never dithered.
  - phase_load does not reseed the LFSR.
- Undefined: no LFSR logic; s1_phase = acc exactly; outputs are bit-exact deterministic.

Decomposition:
- Package sine_phase_pkg: quadrant enum (Q0..Q3), LFSR mask/seed constants, fold function (pure combinational, parameterised by widths).
- One sub-module, lfsr16 (clk, reset_n, step, state out). Instantiated only under SINE_PHASE_DITHER_EN.

Test Plan:
- Reset, enable=1, dout_ready=1, phase_inc=0x2000_0000 -> dout sequence 0x0000, 0x4000, 0x7FFF, 0x4000, 0x0000, 0xC000, 0x8000, 0xC000, repeating; first valid on 2nd edge.
- Backpressure: dout_ready low for 5 cycles mid-stream -> dout and dout_valid held constant; no sample lost or duplicated after release.
- phase_load=1 with phase_load_val=0xC000_0000 while streaming -> in-flight samples dropped; next output 0x8000, then continues from +phase_inc.
- bypass=1, phase_inc=0x0001_0000 -> dout increments by 1 per sample (0x0000, 0x0001, ...); wraps 0xFFFF -> 0x0000 after 65536 samples.
- enable=0 for 3 cycles, then 1 -> dout_valid low during and 1 cycle after; sequence resumes without phase skip.
- Async reset pulse mid-burst (not clock-aligned) -> dout_valid=0 and dout=0 immediately; restart from phase 0. With SINE_PHASE_DITHER_EN, output sequence is bit-matched against a golden model seeded 0xACE1.

Source files
------------

// File: rtl/sine_phase_pkg.sv
// Shared types, constants and helpers for the sine phase folder.
// Quadrant encoding, dither LFSR constants, the Galois LFSR step and the
// triangle fold that maps a quadrant/fraction pair onto x in [-1,1).
package sine_phase_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  // Widest output sample the fold helper supports.
  localparam int          FOLD_MAX_W = 32;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    logic [15:0] nxt;
    nxt = {1'b0, state[15:1]};
    if (state[0]) begin
      nxt = nxt ^ LFSR_MASK;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Fold a quadrant and (dwidth-1)-bit fraction into a two's complement
  // triangle sample. The caller keeps the low dwidth bits of the result.
  // The single out-of-range point (+1.0 at the quadrant 1 start) saturates.
  function automatic logic [FOLD_MAX_W-1:0] fold_arg(
    input quad_e                   quad,
    input logic [FOLD_MAX_W-1:0]   frac,
    input int unsigned             dwidth
  );
    logic [FOLD_MAX_W-1:0] half;
    logic [FOLD_MAX_W-1:0] x;
    half = FOLD_MAX_W'(1'b1) << (dwidth - 32'd1);
    case (quad)
      Q0: x = frac;
      Q1: begin
        if (frac == {FOLD_MAX_W{1'b0}}) begin
          x = half - FOLD_MAX_W'(1'b1);
        end else begin
          x = half - frac;
        end
      end
      Q2:      x = {FOLD_MAX_W{1'b0}} - frac;
      Q3:      x = frac - half;
      default: x = {FOLD_MAX_W{1'b0}};
    endcase
    return x;
  endfunction

endpackage

// File: rtl/sine_phase_fold_if.sv
// Output sample stream of the phase folder: data, valid, ready.
interface sine_phase_fold_if #(
  parameter int G_DWIDTH = 16
);

  logic [G_DWIDTH-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used to dither the low phase bits.
// Seeded on reset and stepped only when requested.
module lfsr16
  import sine_phase_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_r;

  // Advance one Galois step per request, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= LFSR_SEED;
    end else if (step) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/sine_phase_fold.sv
// Phase accumulator and quadrant folder feeding the sine evaluator.
// Each pipeline advance samples the accumulator, then folds it into a
// triangle argument x in [-1,1) (or passes the raw phase MSBs in bypass).
// Optional build macro: SINE_PHASE_DITHER_EN adds LFSR dither to the
// sampled phase (the accumulator itself is never dithered).
module sine_phase_fold
  import sine_phase_pkg::*;
#(
  parameter int G_PWIDTH = 32,
  parameter int G_DWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 bypass,
  input  logic [G_PWIDTH-1:0]  phase_inc,
  input  logic                 phase_load,
  input  logic [G_PWIDTH-1:0]  phase_load_val,
  sine_phase_fold_if.master    bus
);

  // Only the top G_DWIDTH+1 phase bits reach the output; lower bits are
  // truncated, so the first stage keeps just those.
  localparam int S1W = G_DWIDTH + 1;

  logic [G_PWIDTH-1:0] acc_r;
  logic [S1W-1:0]      s1_phase_r;
  logic                s1_valid_r;
  logic [G_DWIDTH-1:0] dout_r;
  logic                dout_valid_r;

  logic                advance_s;
  logic [G_PWIDTH-1:0] dither_s;
  logic [G_DWIDTH-1:0] sample_s;

  assign advance_s = enable & (~dout_valid_r | bus.dout_ready);

`ifdef SINE_PHASE_DITHER_EN
  localparam int DITH_RAW = G_PWIDTH - G_DWIDTH - 1;
  localparam int DITH_W   = (DITH_RAW < 16) ? DITH_RAW : 16;
  localparam logic [G_PWIDTH-1:0] DITH_MASK =
    (G_PWIDTH'(1'b1) << DITH_W) - G_PWIDTH'(1'b1);

  logic [15:0] lfsr_state_s;
  logic        lfsr_step_s;

  // A load suppresses the advance, so the LFSR does not step on it.
  assign lfsr_step_s = advance_s & ~phase_load;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (lfsr_step_s),
    .state   (lfsr_state_s)
  );

  assign dither_s = G_PWIDTH'(lfsr_state_s) & DITH_MASK;
`else
  assign dither_s = {G_PWIDTH{1'b0}};
`endif

  // Map the sampled phase to the output word: folded triangle or sawtooth.
  always_comb begin
    sample_s = {G_DWIDTH{1'b0}};
    if (bypass) begin
      sample_s = s1_phase_r[S1W-1:1];
    end else begin
      sample_s = G_DWIDTH'(fold_arg(quad_e'(s1_phase_r[S1W-1:S1W-2]),
                                    FOLD_MAX_W'(s1_phase_r[S1W-3:0]),
                                    G_DWIDTH));
    end
  end

  // Accumulator and two-stage pipeline: load beats advance, disable flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r        <= {G_PWIDTH{1'b0}};
      s1_phase_r   <= {S1W{1'b0}};
      s1_valid_r   <= 1'b0;
      dout_r       <= {G_DWIDTH{1'b0}};
      dout_valid_r <= 1'b0;
    end else if (phase_load) begin
      acc_r        <= phase_load_val;
      s1_valid_r   <= 1'b0;
      dout_valid_r <= 1'b0;
    end else if (advance_s) begin
      acc_r        <= acc_r + phase_inc;
      s1_phase_r   <= S1W'((acc_r + dither_s) >> (G_PWIDTH - S1W));
      s1_valid_r   <= 1'b1;
      dout_r       <= sample_s;
      dout_valid_r <= s1_valid_r;
    end else if (!enable) begin
      s1_valid_r   <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      acc_r        <= acc_r;
      s1_valid_r   <= s1_valid_r;
      dout_valid_r <= dout_valid_r;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;

endmodule

// File: tb/tb_sine_phase_fold.sv
// Self-checking bench for sine_phase_fold. Expected samples come from a
// triangle-wave reference computed directly from the phase in turns.
module tb_sine_phase_fold;

  localparam int P = 32;
  localparam int D = 16;
  localparam logic [31:0] LOWMASK = 32'hFFFF_0000;
`ifdef SINE_PHASE_DITHER_EN
  localparam logic [31:0] DMASK = 32'h0000_7FFF;
`else
  localparam logic [31:0] DMASK = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        bypass = 1'b0;
  logic        phase_load = 1'b0;
  logic [31:0] phase_inc = 32'h0;
  logic [31:0] phase_load_val = 32'h0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] next_ph;
  logic        byp_m;

  sine_phase_fold_if #(.G_DWIDTH(D)) bus ();

  sine_phase_fold #(.G_PWIDTH(P), .G_DWIDTH(D)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .bypass         (bypass),
    .phase_inc      (phase_inc),
    .phase_load     (phase_load),
    .phase_load_val (phase_load_val),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Reference: x = triangle(phase) with +1.0 saturated; bypass = top 16 bits.
  function automatic logic [15:0] ref_out(input logic [31:0] ph, input logic byp);
    int unsigned u;
    int x;
    if (byp) return ph[31:16];
    u = ph >> 15;
    if (u < 32768) x = int'(u);
    else if (u < 98304) begin
      x = 65536 - int'(u);
      if (x == 32768) x = 32767;
    end else x = int'(u) - 131072;
    return 16'(x);
  endfunction

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [31:0] val, input logic [31:0] inc);
    phase_load_val = val;
    phase_inc = inc;
    phase_load = 1'b1;
    tick();
    phase_load = 1'b0;
    next_ph = val;
  endtask

  task automatic test_reset();
    logic [15:0] tbl [0:7];
    tbl[0] = 16'h0000; tbl[1] = 16'h4000; tbl[2] = 16'h7FFF; tbl[3] = 16'h4000;
    tbl[4] = 16'h0000; tbl[5] = 16'hC000; tbl[6] = 16'h8000; tbl[7] = 16'hC000;
    reset_n = 1'b0; enable = 1'b1; bypass = 1'b0; byp_m = 1'b0;
    phase_inc = 32'h2000_0000; bus.dout_ready = 1'b1;
    repeat (3) tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.dout_valid); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", bus.dout); end
    reset_n = 1'b1;
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid got %b exp 0", bus.dout_valid); end
    tick();
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL second_edge_valid got %b exp 1", bus.dout_valid); end
    next_ph = 32'h0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== tbl[i % 8]) begin
        errors++; $display("FAIL reset_seq[%0d] got v=%b %h exp %h", i, bus.dout_valid, bus.dout, tbl[i % 8]);
      end
      next_ph += phase_inc;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL bp_pre got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
    held = ref_out(next_ph, byp_m);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== held) begin
        errors++; $display("FAIL bp_hold got v=%b %h exp %h", bus.dout_valid, bus.dout, held);
      end
    end
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL bp_post got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
  endtask

  task automatic test_load();
    pulse_load(32'hC000_0000, 32'h2000_0000);
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL load_drop0 got %b exp 0", bus.dout_valid); end
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL load_drop1 got %b exp 0", bus.dout_valid); end
    tick();
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h8000) begin
      errors++; $display("FAIL load_first got v=%b %h exp 8000", bus.dout_valid, bus.dout);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL load_seq got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
  endtask

  task automatic test_bypass();
    bypass = 1'b1; byp_m = 1'b1;
    pulse_load(32'h0, 32'h0001_0000);
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 16'(i)) begin
        errors++; $display("FAIL bypass_ramp[%0d] got v=%b %h", i, bus.dout_valid, bus.dout);
      end
      next_ph += phase_inc;
      tick();
    end
    pulse_load(32'hFFF0_0000, 32'h0001_0000);
    tick(); tick();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL bypass_wrap got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
    // Mid-stream toggle: the sample already in dout keeps bypass formatting.
    pulse_load(32'h5000_0000, 32'h0800_0000);
    tick(); tick();
    bypass = 1'b0;
    checks++;
    if (bus.dout !== ref_out(next_ph, 1'b1)) begin
      errors++; $display("FAIL bypass_toggle_old got %h exp %h", bus.dout, ref_out(next_ph, 1'b1));
    end
    next_ph += phase_inc;
    byp_m = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL bypass_toggle_new got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
  endtask

  task automatic test_enable();
    pulse_load($urandom & LOWMASK, ($urandom & LOWMASK) | 32'h0001_0000);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL en_pre got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL en_off_valid got %b exp 0", bus.dout_valid); end
    end
    enable = 1'b1;
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL en_resume_gap got %b exp 0", bus.dout_valid); end
    tick();
    // The flushed dout and stage-1 samples are gone; resume from held acc.
    next_ph += 2 * phase_inc;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL en_resume got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] prev;
    logic        prev_stall;
    for (int s = 0; s < 4; s++) begin
      bypass = 1'($urandom_range(0, 1));
      byp_m = bypass;
      bus.dout_ready = 1'b1;
      pulse_load($urandom & LOWMASK, $urandom & LOWMASK);
      prev_stall = 1'b0;
      prev = 16'h0;
      for (int c = 0; c < 40; c++) begin
        if (prev_stall) begin
          checks++;
          if (bus.dout_valid !== 1'b1 || bus.dout !== prev) begin
            errors++; $display("FAIL rand_stall got v=%b %h exp %h", bus.dout_valid, bus.dout, prev);
          end
        end
        bus.dout_ready = ($urandom_range(0, 3) != 0);
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev = bus.dout;
        if (bus.dout_valid && bus.dout_ready) begin
          checks++;
          if (bus.dout !== ref_out(next_ph, byp_m)) begin
            errors++; $display("FAIL rand_stream got %h exp %h", bus.dout, ref_out(next_ph, byp_m));
          end
          next_ph += phase_inc;
        end
        tick();
      end
    end
    bypass = 1'b0; byp_m = 1'b0;
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    pulse_load(32'h1000_0000, 32'h2000_0000);
    tick(); tick();
    repeat (3) tick();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", bus.dout_valid); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL areset_dout got %h exp 0000", bus.dout); end
    @(posedge clk);
    #4;
    reset_n = 1'b1;
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL areset_edge1 got %b exp 0", bus.dout_valid); end
    tick();
    next_ph = 32'h0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== ref_out(next_ph, byp_m)) begin
        errors++; $display("FAIL areset_restart got v=%b %h exp %h", bus.dout_valid, bus.dout, ref_out(next_ph, byp_m));
      end
      next_ph += phase_inc;
      tick();
    end
  endtask

  task automatic test_dither();
    logic [31:0] acc_m;
    logic [15:0] lfsr_m;
    logic [15:0] exp;
    bypass = 1'b0; enable = 1'b1; bus.dout_ready = 1'b1;
    phase_inc = $urandom;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    acc_m = 32'h0;
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 40; i++) begin
      exp = ref_out(acc_m + ({16'h0, lfsr_m} & DMASK), 1'b0);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== exp) begin
        errors++; $display("FAIL dither[%0d] got v=%b %h exp %h", i, bus.dout_valid, bus.dout, exp);
      end
      acc_m += phase_inc;
      lfsr_m = lfsr_model(lfsr_m);
      tick();
    end
  endtask

  initial begin
    bus.dout_ready = 1'b1;
    byp_m = 1'b0;
    next_ph = 32'h0;
    test_reset();
    test_backpressure();
    test_load();
    test_bypass();
    test_enable();
    test_random();
    test_async_reset();
    test_dither();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
